// File: rtl/mem_bus_ctrl.sv
// Shared memory bus controller: arbitrates IF and MEM requests onto one req/ack bus,
// lane-aligns stores, extends loads, flags misalignment and bus timeouts.
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    output logic              i_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic              d_ext,
    input  logic              d_signed,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              d_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_RESP = 2'd2} state_t;

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_last_d;
    logic              r_gnt_d;
    logic              r_byte;
    logic              r_half;
    logic              r_signed;
    logic [1:0]        r_lo;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_sel;
    logic [31:0]       r_bus_wdata;
    logic              r_i_done;
    logic              r_i_err;
    logic [31:0]       r_i_rdata;
    logic              r_d_done;
    logic              r_d_err;
    logic [31:0]       r_d_rdata;

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lo,
                                              input logic is_byte, input logic is_half,
                                              input logic sgn);
        logic [31:0] sh;
        sh = word;
        if (is_byte) begin
            sh = word >> {lo, 3'b000};
            return {{24{sgn & sh[7]}}, sh[7:0]};
        end
        if (is_half) begin
            sh = word >> {lo[1], 4'b0000};
            return {{16{sgn & sh[15]}}, sh[15:0]};
        end
        return sh;
    endfunction

    logic              w_d_req;
    logic              w_any;
    logic              w_gnt_d;
    logic [ADDR_W-1:0] w_addr;
    logic              w_byte;
    logic              w_half;
    logic              w_mis;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdata;
    logic              w_tmo;
    logic [31:0]       w_load;
    logic              w_resp;
    logic              w_rsp_d;
    logic              w_rsp_err;
    logic [31:0]       w_rsp_data;

    // With both pending, the requester not served last wins; last_grant resets to INST.
    assign w_d_req  = d_read | d_write;
    assign w_any    = i_req | w_d_req;
    assign w_gnt_d  = w_d_req & (~i_req | ~r_last_d);
    assign w_addr   = w_gnt_d ? d_addr : i_addr;
    assign w_byte   = w_gnt_d & d_ext & (d_sel == 4'b0001);
    assign w_half   = w_gnt_d & d_ext & (d_sel == 4'b0011);
    assign w_mis    = w_byte ? 1'b0 : (w_half ? w_addr[0] : (w_addr[1:0] != 2'b00));
    assign w_sel    = w_byte ? (4'b0001 << w_addr[1:0])
                             : (w_half ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111);
    assign w_wdata  = w_byte ? {4{d_wdata[7:0]}} : (w_half ? {2{d_wdata[15:0]}} : d_wdata);
    assign w_tmo    = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign w_load   = f_extract(bus_rdata, r_lo, r_byte, r_half, r_signed);

    // A response is produced either straight from IDLE (misaligned) or when ACC ends.
    assign w_resp     = (r_state == S_IDLE) ? (w_any & w_mis)
                                            : ((r_state == S_ACC) & (bus_ack | w_tmo));
    assign w_rsp_d    = (r_state == S_IDLE) ? w_gnt_d : r_gnt_d;
    assign w_rsp_err  = (r_state == S_IDLE) | ~bus_ack;
    assign w_rsp_data = w_rsp_err ? 32'd0
                                  : (w_rsp_d ? (r_bus_we ? 32'd0 : w_load) : bus_rdata);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_last_d    <= 1'b0;
            r_gnt_d     <= 1'b0;
            r_byte      <= 1'b0;
            r_half      <= 1'b0;
            r_signed    <= 1'b0;
            r_lo        <= 2'b00;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'd0;
            r_i_done    <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rdata   <= 32'd0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= 32'd0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            if (w_resp) begin
                if (w_rsp_d) begin
                    r_d_done  <= 1'b1;
                    r_d_err   <= w_rsp_err;
                    r_d_rdata <= w_rsp_data;
                end else begin
                    r_i_done  <= 1'b1;
                    r_i_err   <= w_rsp_err;
                    r_i_rdata <= w_rsp_data;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_d <= w_gnt_d;
                        if (w_mis) begin
                            r_state <= S_RESP;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= w_gnt_d & d_write;
                            r_bus_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
                            r_bus_sel   <= w_sel;
                            r_bus_wdata <= w_wdata;
                            r_lo        <= w_addr[1:0];
                            r_byte      <= w_byte;
                            r_half      <= w_half;
                            r_signed    <= w_gnt_d & d_signed;
                            r_state     <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (bus_ack | w_tmo) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_last_d <= r_gnt_d;
                    r_cnt    <= 8'd0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign i_stall   = i_req & ~r_i_done;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign d_stall   = w_d_req & ~r_d_done;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_sel   = r_bus_sel;
    assign bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed cases plus random transactions against a
// transaction-level model of the access rules, with a small bus slave.
module tb_mem_bus_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        i_stall;
    logic        d_read;
    logic        d_write;
    logic        d_ext;
    logic        d_signed;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_bad = 0;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .i_err(i_err), .i_stall(i_stall),
        .d_read(d_read), .d_write(d_write), .d_ext(d_ext), .d_signed(d_signed),
        .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    // One access from a single requester; lat = bus cycle index at which the slave acks.
    task automatic run_acc(input bit inst, input bit rd, input bit wr, input bit ext,
                           input bit sgn, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int lat);
        int size, a, nreq, done_exp, reqcnt, done_cyc, scnt;
        bit is_w, mis, tmo, started, done, stall_ok, stable_ok, other_ok, dn;
        logic [31:0] e_sel, e_wd, e_rd, v, g_rd, f_addr, f_wd;
        logic [3:0] f_sel;
        logic g_err, f_we;
        reqcnt = 0; done_cyc = -1; scnt = 0; started = 0; done = 0;
        stall_ok = 1; stable_ok = 1; other_ok = 1;
        g_rd = 32'd0; g_err = 1'b0; f_addr = 32'd0; f_wd = 32'd0; f_sel = 4'd0; f_we = 1'b0;
        is_w = !inst && wr;
        if (inst || !ext) size = 4;
        else if (sel == 4'b0001) size = 1;
        else if (sel == 4'b0011) size = 2;
        else size = 4;
        a = int'(addr % 4);
        mis = (size == 2 && a % 2 == 1) || (size == 4 && a != 0);
        tmo = !mis && lat >= TO;
        nreq = mis ? 0 : (tmo ? TO : lat + 1);
        done_exp = nreq + 1;
        e_sel = (size == 1) ? (32'd1 << a) : ((size == 2) ? (32'd3 << (a / 2 * 2)) : 32'd15);
        e_wd = (size == 1) ? (wd & 32'hFF) * 32'h01010101
             : ((size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd);
        if (mis || tmo || is_w) e_rd = 32'd0;
        else if (size == 4) e_rd = rdat;
        else if (size == 1) begin
            v = (rdat >> (8 * a)) & 32'hFF;
            if (sgn && v >= 128) v = v - 256;
            e_rd = v;
        end else begin
            v = (rdat >> (16 * (a / 2))) & 32'hFFFF;
            if (sgn && v >= 32768) v = v - 65536;
            e_rd = v;
        end
        if (inst) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_read = rd; d_write = wr; d_ext = ext; d_signed = sgn;
            d_sel = sel; d_addr = addr; d_wdata = wd;
        end
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            #1;
            if (bus_req && !started) begin started = 1; scnt = 0; end
            bus_ack = started && (scnt == lat);
            bus_rdata = bus_ack ? rdat : $urandom;
            if (bus_req) begin
                if (reqcnt == 0) begin
                    f_addr = bus_addr; f_sel = bus_sel; f_we = bus_we; f_wd = bus_wdata;
                end else if (bus_addr !== f_addr || bus_sel !== f_sel || bus_we !== f_we
                             || bus_wdata !== f_wd) begin
                    stable_ok = 0;
                end
                reqcnt++;
            end
            dn = inst ? i_done : d_done;
            if (inst ? d_done : i_done) other_ok = 0;
            if ((inst ? i_stall : d_stall) !== !dn) stall_ok = 0;
            if (dn) begin
                done = 1; done_cyc = cyc;
                g_rd = inst ? i_rdata : d_rdata;
                g_err = inst ? i_err : d_err;
            end
            if (started) scnt++;
            @(negedge clk);
        end
        clear_reqs();
        bus_ack = 1'b0;
        #1;
        chk("done_seen", 32'(done), 32'd1);
        chk("done_cycle", 32'(done_cyc), 32'(done_exp));
        chk("err", 32'(g_err), 32'(mis || tmo));
        chk("rdata", g_rd, e_rd);
        chk("bus_req_cycles", 32'(reqcnt), 32'(nreq));
        chk("stall", 32'(stall_ok), 32'd1);
        chk("other_done", 32'(other_ok), 32'd1);
        chk("idle_after_req", 32'(bus_req), 32'd0);
        chk("done_single", 32'(i_done | d_done), 32'd0);
        if (nreq > 0) begin
            chk("bus_addr", f_addr, addr & ~32'd3);
            chk("bus_sel", 32'(f_sel), e_sel);
            chk("bus_we", 32'(f_we), 32'(is_w));
            chk("bus_stable", 32'(stable_ok), 32'd1);
            if (is_w) chk("bus_wdata", f_wd, e_wd);
        end
    endtask

    initial begin
        int rises, nd;
        bit prev, lastg, g;
        bit order[$];
        bit inst, rd, wr, ext, sgn;
        int k, size;
        logic [3:0] sel;
        logic [31:0] addr;

        rst = 1'b0; clear_reqs();
        i_addr = 32'd0; d_ext = 1'b0; d_signed = 1'b0; d_sel = 4'd0; d_addr = 32'd0;
        d_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_dones", 32'({i_done, d_done}), 32'd0);
        chk("rst_errs", 32'({i_err, d_err}), 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        chk("rst_stalls", 32'({i_stall, d_stall}), 32'd0);
        rst = 1'b1;

        // Directed accesses
        run_acc(0, 1, 0, 0, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_acc(0, 1, 0, 1, 1, 4'b0001, 32'h103, 32'h0, 32'h80123456, 0);
        run_acc(0, 1, 0, 1, 0, 4'b0001, 32'h103, 32'h0, 32'h80123456, 1);
        run_acc(0, 1, 0, 1, 1, 4'b0011, 32'h102, 32'h0, 32'h80123456, 2);
        run_acc(0, 0, 1, 1, 0, 4'b0001, 32'h201, 32'hAB, 32'h12345678, 0);
        run_acc(0, 1, 1, 1, 0, 4'b0011, 32'h206, 32'hCAFE1234, 32'h0, 1);
        run_acc(0, 1, 0, 1, 1, 4'b0011, 32'h101, 32'h0, 32'h0, 0);
        run_acc(1, 0, 0, 0, 0, 4'b0000, 32'h6, 32'h0, 32'h0, 0);
        run_acc(1, 0, 0, 0, 0, 4'b0000, 32'h40, 32'h0, 32'h13579BDF, 3);
        run_acc(0, 1, 0, 0, 0, 4'b1111, 32'h400, 32'h0, 32'h11112222, 99);
        run_acc(0, 0, 1, 0, 0, 4'b1111, 32'h404, 32'h55667788, 32'h0, TO);

        // Reset while an access is outstanding
        d_read = 1'b1; d_ext = 1'b0; d_sel = 4'b1111; d_addr = 32'h300;
        @(negedge clk); @(negedge clk); #1;
        chk("mid_req_before", 32'(bus_req), 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_req_after_rst", 32'(bus_req), 32'd0);
        chk("mid_done_after_rst", 32'(d_done), 32'd0);
        clear_reqs();
        rst = 1'b1;
        @(negedge clk); #1;
        run_acc(0, 1, 0, 0, 0, 4'b1111, 32'h304, 32'h0, 32'hA5A55A5A, 0);

        // Both requesters held from reset: expect alternation starting with data
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        d_read = 1'b1; d_write = 1'b0; d_ext = 1'b0; d_sel = 4'b1111; d_addr = 32'h80;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        rises = 0; prev = 1'b0; nd = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            bus_ack = bus_req;
            bus_rdata = bus_addr ^ 32'h55AA0000;
            if (bus_req && !prev) rises++;
            prev = bus_req;
            if (d_done) begin order.push_back(1'b1); chk("arb_d_rdata", d_rdata, 32'h55AA0080); end
            if (i_done) begin order.push_back(1'b0); chk("arb_i_rdata", i_rdata, 32'h55AA0040); end
            @(negedge clk);
        end
        clear_reqs(); bus_ack = 1'b0;
        chk("arb_count", 32'(order.size()), 32'd4);
        chk("arb_rises", 32'(rises), 32'd4);
        lastg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g = !lastg;
            chk("arb_order", (order.size() > i) ? 32'(order[i]) : 32'd2, 32'(g));
            lastg = g;
        end
        @(negedge clk);

        // Random transactions
        for (int t = 0; t < 60; t++) begin
            k = $urandom_range(0, 8);
            inst = (k == 0);
            sgn = $urandom_range(0, 1) == 1;
            rd = 1'b0; wr = 1'b0; ext = 1'b0; sel = 4'b1111; size = 4;
            case (k)
                2, 3: begin ext = 1; sel = 4'b0011; size = 2; end
                4, 5: begin ext = 1; sel = 4'b0001; size = 1; end
                7:    begin ext = 1; sel = 4'b0011; size = 2; end
                8:    begin ext = 1; sel = 4'b0001; size = 1; end
                default: ;
            endcase
            if (k == 3 || k == 5) sgn = 0;
            if (k >= 1 && k <= 5) begin rd = 1; wr = ($urandom_range(0, 7) == 0); end
            if (k >= 6) begin wr = 1; rd = ($urandom_range(0, 3) == 0); end
            addr = $urandom & 32'hFFFF;
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
            run_acc(inst, rd, wr, ext, sgn, sel, addr, $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
